// File: rtl/backscatter_pkg.sv
// Shared types and constants for the backscatter transmit scheduler.
package backscatter_pkg;

    // Scheduler FSM states. The encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GUARD = 2'd3
    } state_t;

    // Payload word width of the data_source serializer input.
    localparam int WORD_W_DEFAULT = 10;

    // Largest value the completed-burst counter holds before wrapping to zero.
    localparam int BURST_MAX = 65535;

    // Number of bits needed to represent max_val (at least 1).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((max_val >> w) != 0) begin
            w = w + 1;
        end
        return w;
    endfunction

    localparam int BURST_W = cnt_width(BURST_MAX);

endpackage

// File: rtl/backscatter_tx_scheduler_rr_arbiter.sv
// Round-robin picker: first asserted request starting at rr_ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_grant
);

    // Scan rr_ptr, rr_ptr+1, ... and keep the first hit; later hits are ignored.
    always_comb begin
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int cand;
            logic [IDX_W-1:0] cidx;
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cidx = IDX_W'(cand);
            if (!any_grant && req[cidx]) begin
                any_grant = 1'b1;
                grant_idx = cidx;
            end
        end
    end

endmodule

// File: rtl/backscatter_tx_scheduler.sv
// Shares the data_source serializer among NUM_REQ payload producers. Arbitration is
// round-robin at each burst start; the grant is then locked until the burst ends or
// aborts, and every burst/abort is followed by GUARD_CYCLES idle clocks.
//
// Handshake: a requester holds req_valid[i] with req_word/req_last stable until it
// sees req_ready[i]; the word is taken on the rising edge where both are high.
// req_ready is one-hot, only high in LOAD while sending=1, and never depends on
// anything but registered state and the current requester/sending inputs.
module backscatter_tx_scheduler
    import backscatter_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int WORD_W       = WORD_W_DEFAULT,
    parameter int GUARD_CYCLES = 64,
    parameter int IDX_W        = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sending,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*WORD_W-1:0] req_word,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      tx_done,
    output logic [WORD_W-1:0]         tx_word,
    output logic                      tx_valid,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy,
    output logic                      tx_abort,
    output logic [BURST_W-1:0]        burst_count,
    output logic [1:0]                state_dbg
);

    localparam int GCNT_W = cnt_width(GUARD_CYCLES);
    localparam logic [GCNT_W-1:0] GUARD_LAST = GCNT_W'(GUARD_CYCLES - 1);

    state_t             state;
    logic [IDX_W-1:0]   rr_ptr;
    logic               last_flag;
    logic [GCNT_W-1:0]  guard_cnt;

    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic [WORD_W-1:0]  sel_word;
    logic               sel_last;
    logic               sel_valid;
    logic               accept;

    // Pointer to the requester after i, wrapping at NUM_REQ (need not be a power of two).
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (int'(i) == NUM_REQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req_valid),
        .rr_ptr    (rr_ptr),
        .grant_idx (arb_idx),
        .any_grant (arb_any)
    );

    // Select the locked requester's word, last flag and valid.
    always_comb begin
        sel_word  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDX_W'(i)) begin
                sel_word  = req_word[i*WORD_W +: WORD_W];
                sel_last  = req_last[i];
                sel_valid = req_valid[i];
            end
        end
    end

    assign accept = (state == LOAD) && sending && sel_valid;

    // Accept strobe toward the granted requester; combinational so a word is never
    // acknowledged after the requester has withdrawn it.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

    // Scheduler FSM with its data/last latches, guard counter and burst counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            last_flag   <= 1'b0;
            tx_word     <= '0;
            tx_valid    <= 1'b0;
            tx_abort    <= 1'b0;
            burst_count <= '0;
            guard_cnt   <= '0;
        end else begin
            tx_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (sending && arb_any) begin
                        grant_id <= arb_idx;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    if (!sending) begin
                        // Window closed before any word left: no abort, pointer kept.
                        guard_cnt <= '0;
                        state     <= GUARD;
                    end else if (sel_valid) begin
                        tx_word   <= sel_word;
                        last_flag <= sel_last;
                        tx_valid  <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!sending) begin
                        // Abort outranks a coincident tx_done; skip this requester next time.
                        tx_abort  <= 1'b1;
                        tx_valid  <= 1'b0;
                        rr_ptr    <= next_idx(grant_id);
                        guard_cnt <= '0;
                        state     <= GUARD;
                    end else if (tx_done) begin
                        tx_valid <= 1'b0;
                        if (last_flag) begin
                            burst_count <= burst_count + 1'b1;
                            rr_ptr      <= next_idx(grant_id);
                            guard_cnt   <= '0;
                            state       <= GUARD;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                GUARD: begin
                    if (guard_cnt == GUARD_LAST) begin
                        state <= IDLE;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_backscatter_tx_scheduler.sv
// Directed bench for backscatter_tx_scheduler: requester model, data_source model
// (tx_done pulses), expected queues filled by the stimulus and a negedge monitor.
module tb_backscatter_tx_scheduler;
    import backscatter_pkg::*;

    localparam int NUM_REQ      = 4;
    localparam int WORD_W       = 10;
    localparam int GUARD_CYCLES = 64;
    localparam int IDX_W        = 2;
    localparam int WAIT_MAX     = 500;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic                      sending = 1'b0;
    logic [NUM_REQ-1:0]        req_valid = '0;
    logic [NUM_REQ*WORD_W-1:0] req_word = '0;
    logic [NUM_REQ-1:0]        req_last = '0;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      tx_done = 1'b0;
    logic [WORD_W-1:0]         tx_word;
    logic                      tx_valid;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;
    logic                      tx_abort;
    logic [15:0]               burst_count;
    logic [1:0]                state_dbg;

    backscatter_tx_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .WORD_W       (WORD_W),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sending     (sending),
        .req_valid   (req_valid),
        .req_word    (req_word),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_done     (tx_done),
        .tx_word     (tx_word),
        .tx_valid    (tx_valid),
        .grant_id    (grant_id),
        .busy        (busy),
        .tx_abort    (tx_abort),
        .burst_count (burst_count),
        .state_dbg   (state_dbg)
    );

    // ---------------- requester model ----------------
    logic [WORD_W:0]    src_mem [NUM_REQ][16];
    int                 src_wr [NUM_REQ];
    int                 src_rd [NUM_REQ];
    logic [NUM_REQ-1:0] hold_mask = '0;
    logic [NUM_REQ-1:0] take = '0;

    always @(negedge clock) take = req_valid & req_ready;

    always @(posedge clock) begin
        logic [NUM_REQ-1:0]        v;
        logic [NUM_REQ-1:0]        l;
        logic [NUM_REQ*WORD_W-1:0] w;
        logic [WORD_W:0]           ent;
        #1;
        v = '0;
        l = '0;
        w = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (take[i]) src_rd[i] = src_rd[i] + 1;
            if (src_rd[i] != src_wr[i] && !hold_mask[i]) begin
                ent = src_mem[i][src_rd[i] % 16];
                v[i] = 1'b1;
                l[i] = ent[WORD_W];
                w[i*WORD_W +: WORD_W] = ent[WORD_W-1:0];
            end
        end
        req_valid = v;
        req_last  = l;
        req_word  = w;
    end

    // ---------------- scoreboard ----------------
    logic [IDX_W-1:0]  exp_acc_q[$];
    logic [WORD_W-1:0] exp_word_q[$];
    logic [16:0]       exp_end_q[$];   // {abort, burst_count after the burst}
    logic [1:0]        exp_state_q[$];
    string             timeout_q[$];
    int                n_cmp = 0;
    int                n_err = 0;
    int                abort_seen = 0;
    int                exp_aborts = 0;
    int                guard_len = 0;
    logic [1:0]        prev_state = 2'd0;
    logic              prev_txv = 1'b0;
    logic              rst_checked = 1'b0;
    logic [WORD_W-1:0] cur_word = '0;
    logic              end_req = 1'b0;
    logic              end_done = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [IDX_W-1:0] ready_idx(input logic [NUM_REQ-1:0] r);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_REQ; i++) if (r[i]) idx = IDX_W'(i);
        return idx;
    endfunction

    // Monitor: samples on the falling edge, pops expectations as DUT events appear.
    always @(negedge clock) begin
        logic [16:0] e;
        if (!reset) begin
            if (!rst_checked) begin
                check("rst_req_ready",   32'(req_ready), 32'd0);
                check("rst_tx_word",     32'(tx_word), 32'd0);
                check("rst_tx_valid",    32'(tx_valid), 32'd0);
                check("rst_grant_id",    32'(grant_id), 32'd0);
                check("rst_busy",        32'(busy), 32'd0);
                check("rst_tx_abort",    32'(tx_abort), 32'd0);
                check("rst_burst_count", 32'(burst_count), 32'd0);
                check("rst_state",       32'(state_dbg), 32'(IDLE));
                rst_checked = 1'b1;
            end
            prev_state = 2'(IDLE);
            prev_txv   = 1'b0;
            guard_len  = 0;
        end else begin
            rst_checked = 1'b0;
            while (timeout_q.size() > 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL timeout %s: got no event, expected one within %0d cycles", timeout_q.pop_front(), WAIT_MAX);
            end
            if (exp_state_q.size() > 0)
                check("state_probe", 32'(state_dbg), 32'(exp_state_q.pop_front()));
            if (req_ready != '0) begin
                check("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                if (exp_acc_q.size() == 0) begin
                    check("unexpected_accept", 32'(req_ready), 32'd0);
                end else begin
                    e = 17'(exp_acc_q.pop_front());
                    check("accept_idx", 32'(ready_idx(req_ready)), 32'(e));
                    check("grant_id",   32'(grant_id), 32'(e));
                end
            end
            if (tx_valid && !prev_txv) begin
                if (exp_word_q.size() == 0) begin
                    check("unexpected_tx_valid", 32'(tx_valid), 32'd0);
                end else begin
                    cur_word = exp_word_q.pop_front();
                    check("tx_word", 32'(tx_word), 32'(cur_word));
                end
            end
            if (tx_valid && tx_done)
                check("tx_word_hold", 32'(tx_word), 32'(cur_word));
            if (tx_abort) abort_seen++;
            if (state_dbg == 2'(GUARD) && prev_state != 2'(GUARD)) begin
                if (exp_end_q.size() == 0) begin
                    check("unexpected_burst_end", 32'(state_dbg), 32'(SHIFT));
                end else begin
                    e = exp_end_q.pop_front();
                    check("end_tx_abort",    32'(tx_abort), 32'(e[16]));
                    check("end_burst_count", 32'(burst_count), 32'(e[15:0]));
                    check("end_tx_valid",    32'(tx_valid), 32'd0);
                    check("end_busy",        32'(busy), 32'd1);
                end
            end
            if (state_dbg == 2'(GUARD)) guard_len++;
            if (prev_state == 2'(GUARD) && state_dbg != 2'(GUARD)) begin
                check("guard_len", 32'(guard_len), 32'(GUARD_CYCLES));
                guard_len = 0;
            end
            if (end_req && !end_done) begin
                check("left_accepts", 32'(exp_acc_q.size()), 32'd0);
                check("left_words",   32'(exp_word_q.size()), 32'd0);
                check("left_ends",    32'(exp_end_q.size()), 32'd0);
                check("abort_pulses", 32'(abort_seen), 32'(exp_aborts));
                end_done = 1'b1;
            end
            prev_state = state_dbg;
            prev_txv   = tx_valid;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic push_word(input int i, input logic [WORD_W-1:0] w, input logic last);
        src_mem[i][src_wr[i] % 16] = {last, w};
        src_wr[i] = src_wr[i] + 1;
    endtask

    task automatic expect_burst(input logic abrt, input logic [15:0] cnt);
        exp_end_q.push_back({abrt, cnt});
    endtask

    task automatic wait_txv(input string tag);
        int n;
        n = 0;
        while (tx_valid !== 1'b1 && n < WAIT_MAX) begin
            tick(1);
            n++;
        end
        if (n >= WAIT_MAX) timeout_q.push_back(tag);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (state_dbg !== 2'(IDLE) && n < WAIT_MAX) begin
            tick(1);
            n++;
        end
        if (n >= WAIT_MAX) timeout_q.push_back(tag);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
    endtask

    task automatic serve(input int delay, input string tag);
        wait_txv(tag);
        tick(delay);
        pulse_done();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        tick(3);
        reset = 1'b1;
        tick(2);

        // All four valid, single-word bursts: grants 0,1,2,3,0.
        push_word(0, 10'h010, 1'b1);
        push_word(0, 10'h011, 1'b1);
        push_word(1, 10'h020, 1'b1);
        push_word(2, 10'h030, 1'b1);
        push_word(3, 10'h040, 1'b1);
        exp_acc_q  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_word_q = '{10'h010, 10'h020, 10'h030, 10'h040, 10'h011};
        for (int b = 1; b <= 5; b++) expect_burst(1'b0, 16'(b));
        sending = 1'b1;
        for (int b = 0; b < 5; b++) serve(3, "rr_burst");
        wait_idle("rr_idle");

        // Requester 2 alone, three words, tx_done 20 cycles after each word.
        push_word(2, 10'h101, 1'b0);
        push_word(2, 10'h102, 1'b0);
        push_word(2, 10'h303, 1'b1);
        exp_acc_q  = '{2'd2, 2'd2, 2'd2};
        exp_word_q = '{10'h101, 10'h102, 10'h303};
        expect_burst(1'b0, 16'd6);
        for (int b = 0; b < 3; b++) serve(20, "multi_word");
        wait_idle("multi_idle");

        // rr_ptr=3 now; abort requester 3 five cycles into SHIFT, then 0 before 3.
        push_word(3, 10'h2A5, 1'b1);
        push_word(0, 10'h155, 1'b1);
        push_word(3, 10'h0F3, 1'b1);
        exp_acc_q  = '{2'd3, 2'd0, 2'd3};
        exp_word_q = '{10'h2A5, 10'h155, 10'h0F3};
        expect_burst(1'b1, 16'd6);
        expect_burst(1'b0, 16'd7);
        expect_burst(1'b0, 16'd8);
        exp_aborts++;
        wait_txv("abort_word");
        tick(5);
        sending = 1'b0;
        tick(2);
        sending = 1'b1;
        serve(4, "after_abort0");
        serve(4, "after_abort1");
        wait_idle("abort_idle");

        // tx_done and sending falling together: abort wins, no count.
        push_word(1, 10'h1E1, 1'b1);
        exp_acc_q.push_back(2'd1);
        exp_word_q.push_back(10'h1E1);
        expect_burst(1'b1, 16'd8);
        exp_aborts++;
        wait_txv("race_word");
        tick(3);
        sending = 1'b0;
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
        sending = 1'b1;
        wait_idle("race_idle");

        // Requester 1 withdraws in LOAD for 10 cycles while requester 2 waits.
        push_word(1, 10'h211, 1'b0);
        push_word(1, 10'h212, 1'b1);
        exp_acc_q  = '{2'd1, 2'd1, 2'd2};
        exp_word_q = '{10'h211, 10'h212, 10'h222};
        expect_burst(1'b0, 16'd9);
        expect_burst(1'b0, 16'd10);
        wait_txv("withdraw_word");
        hold_mask[1] = 1'b1;
        push_word(2, 10'h222, 1'b1);
        tick(3);
        pulse_done();
        exp_state_q.push_back(2'(LOAD));
        tick(5);
        exp_state_q.push_back(2'(LOAD));
        tick(5);
        exp_state_q.push_back(2'(LOAD));
        hold_mask[1] = 1'b0;
        serve(3, "resume_word");
        serve(3, "other_word");
        wait_idle("withdraw_idle");

        // Reset mid-SHIFT, then arbitration restarts at requester 0.
        push_word(3, 10'h333, 1'b1);
        exp_acc_q.push_back(2'd3);
        exp_word_q.push_back(10'h333);
        wait_txv("reset_word");
        tick(4);
        @(posedge clock);
        #2;
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        push_word(0, 10'h0A0, 1'b1);
        push_word(3, 10'h0B3, 1'b1);
        exp_acc_q  = '{2'd0, 2'd3};
        exp_word_q = '{10'h0A0, 10'h0B3};
        expect_burst(1'b0, 16'd1);
        expect_burst(1'b0, 16'd2);
        serve(3, "post_reset0");
        serve(3, "post_reset1");
        wait_idle("post_reset_idle");

        tick(2);
        end_req = 1'b1;
        for (int n = 0; n < 10 && !end_done; n++) tick(1);
        if (!end_done) $display("FAIL final_drain: got no final check, expected one");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + (end_done ? 0 : 1));
        $finish;
    end

endmodule
